// File: rtl/gsensor_frame_parser.sv
// gsensor_frame_parser
//   Decodes the ASCII accelerometer frame "<xxxx|yyyy|zzzz>\n" (hex digits,
//   MSB nibble first) from a uart_rx byte stream. It produces three
//   4*DIGITS-bit values. A well-formed frame gives a one-cycle data_valid
//   pulse. A malformed frame gives a one-cycle frame_error pulse and bumps a
//   saturating error counter.
//
// Parameters
//   DIGITS         hex digits per axis field (output width 4*DIGITS)
//   REQUIRE_NL     1: frame ends with ">" then "\n"; 0: frame ends at ">"
//   TIMEOUT_CYCLES idle clocks before a partial frame is aborted
//                  (used only when GSENSOR_FRAME_PARSER_TIMEOUT_EN is defined)
//
// Optional feature
//   `define GSENSOR_FRAME_PARSER_TIMEOUT_EN enables the partial-frame timeout.
//
// Ports
//   clk, rstn           clock, asynchronous active-low reset
//   i_tvalid, i_tdata   byte stream from uart_rx
//   o_tready            1 whenever out of reset (never stalls)
//   data_valid          one-cycle pulse, data_x/y/z hold a new frame
//   data_x/y/z          last successfully decoded fields
//   frame_error         one-cycle pulse, a frame was aborted
//   error_count         aborted-frame count, saturating at 255

module gsensor_frame_parser #(
  parameter int DIGITS         = 4,
  parameter int REQUIRE_NL     = 1,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_tvalid,
  input  logic [7:0]            i_tdata,
  output logic                  o_tready,
  output logic                  data_valid,
  output logic [4*DIGITS-1:0]   data_x,
  output logic [4*DIGITS-1:0]   data_y,
  output logic [4*DIGITS-1:0]   data_z,
  output logic                  frame_error,
  output logic [7:0]            error_count
);

  localparam int DATA_W = 4 * DIGITS;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [7:0] CH_LT  = 8'h3C;  // '<'
  localparam logic [7:0] CH_GT  = 8'h3E;  // '>'
  localparam logic [7:0] CH_BAR = 8'h7C;  // '|'
  localparam logic [7:0] CH_NL  = 8'h0A;  // '\n'

  typedef enum logic [2:0] {IDLE, FX, S1, FY, S2, FZ, CL, NL} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    dig_cnt;
  logic [DATA_W-1:0]   sh_reg;
  logic [DATA_W-1:0]   sh_nxt;
  logic [DATA_W-1:0]   stg_x, stg_y, stg_z;

  logic                clr_field;
  logic                shift_en;
  logic                field_done;
  logic                commit;
  logic                err;
  logic                last_digit;
  logic                byte_hex;
  logic [3:0]          byte_nib;

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) ||
           (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  // Letters 'A'/'a' have low nibble 1, so adding 9 maps them onto 10..15.
  function automatic logic [3:0] hex_val(input logic [7:0] b);
    if (b <= 8'h39) return b[3:0];
    else            return b[3:0] + 4'd9;
  endfunction

  assign o_tready   = rstn;
  assign byte_hex   = is_hex(i_tdata);
  assign byte_nib   = hex_val(i_tdata);
  assign sh_nxt     = (sh_reg << 4) | DATA_W'(byte_nib);
  assign last_digit = (dig_cnt == CNT_W'(DIGITS - 1));

`ifdef GSENSOR_FRAME_PARSER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

  // The counter only runs inside a frame and restarts on every accepted byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          tmo_cnt <= '0;
    else if (state == IDLE || i_tvalid) tmo_cnt <= '0;
    else if (!tmo_hit)                  tmo_cnt <= tmo_cnt + TMO_W'(1);
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    clr_field  = 1'b0;
    shift_en   = 1'b0;
    field_done = 1'b0;
    commit     = 1'b0;
    err        = 1'b0;
    if (i_tvalid) begin
      case (state)
        IDLE: begin
          if (i_tdata == CH_LT) begin
            state_nxt = FX;
            clr_field = 1'b1;
          end
        end
        FX, FY, FZ: begin
          if (byte_hex) begin
            shift_en = 1'b1;
            if (last_digit) begin
              field_done = 1'b1;
              state_nxt  = (state == FX) ? S1 : (state == FY) ? S2 : CL;
            end
          end else begin
            err = 1'b1;
          end
        end
        S1, S2: begin
          if (i_tdata == CH_BAR) begin
            state_nxt = (state == S1) ? FY : FZ;
            clr_field = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
        CL: begin
          if (i_tdata == CH_GT) begin
            if (REQUIRE_NL != 0) begin
              state_nxt = NL;
            end else begin
              state_nxt = IDLE;
              commit    = 1'b1;
            end
          end else begin
            err = 1'b1;
          end
        end
        NL: begin
          if (i_tdata == CH_NL) begin
            state_nxt = IDLE;
            commit    = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
      // A '<' inside a frame aborts it but also starts the next one.
      if (err) begin
        state_nxt = (i_tdata == CH_LT) ? FX : IDLE;
        clr_field = (i_tdata == CH_LT);
      end
    end
`ifdef GSENSOR_FRAME_PARSER_TIMEOUT_EN
    else if (tmo_hit && state != IDLE) begin
      err       = 1'b1;
      state_nxt = IDLE;
    end
`endif
  end

  // Byte accept edge -> field shift, staging, registered pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dig_cnt     <= '0;
      sh_reg      <= '0;
      stg_x       <= '0;
      stg_y       <= '0;
      stg_z       <= '0;
      data_x      <= '0;
      data_y      <= '0;
      data_z      <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      error_count <= '0;
    end else begin
      data_valid  <= commit;
      frame_error <= err;

      if (clr_field) begin
        dig_cnt <= '0;
        sh_reg  <= '0;
      end else if (shift_en) begin
        sh_reg  <= sh_nxt;
        dig_cnt <= last_digit ? '0 : dig_cnt + CNT_W'(1);
      end

      if (err) begin
        stg_x <= '0;
        stg_y <= '0;
        stg_z <= '0;
      end else if (field_done) begin
        case (state)
          FX:      stg_x <= sh_nxt;
          FY:      stg_y <= sh_nxt;
          default: stg_z <= sh_nxt;
        endcase
      end

      if (commit) begin
        data_x <= stg_x;
        data_y <= stg_y;
        data_z <= stg_z;
      end

      if (err && error_count != 8'hFF) error_count <= error_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_gsensor_frame_parser.sv
module tb_gsensor_frame_parser;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_tvalid;
  logic [7:0]  i_tdata;
  logic        o_tready;
  logic        data_valid;
  logic [15:0] data_x, data_y, data_z;
  logic        frame_error;
  logic [7:0]  error_count;

  gsensor_frame_parser #(
    .DIGITS(4), .REQUIRE_NL(1), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rstn(rstn), .i_tvalid(i_tvalid), .i_tdata(i_tdata),
    .o_tready(o_tready), .data_valid(data_valid),
    .data_x(data_x), .data_y(data_y), .data_z(data_z),
    .frame_error(frame_error), .error_count(error_count)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int nv_tot = 0;
  int ne_tot = 0;
  int both_tot = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (data_valid) nv_tot++;
      if (frame_error) ne_tot++;
      if (data_valid && frame_error) both_tot++;
    end
  end

  typedef struct {
    string       s;
    int          gap;
    int          nv;
    int          ne;
    logic [15:0] x, y, z;
    logic [7:0]  ec;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_tvalid = 1'b1;
    i_tdata  = b;
    @(posedge clk); #1;
    if (gap > 0) begin
      i_tvalid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
    i_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int v0, e0;
    vt[0] = '{"<1A2b|00FF|8000>\n", 3, 1, 0, 16'h1A2B, 16'h00FF, 16'h8000, 8'd0};
    vt[1] = '{"<12G4|",              3, 0, 1, 16'h1A2B, 16'h00FF, 16'h8000, 8'd1};
    vt[2] = '{"<0001|0002|0003>\n", 3, 1, 0, 16'h0001, 16'h0002, 16'h0003, 8'd1};
    vt[3] = '{"<1234<5678|9ABC|DEF0>\n", 1, 1, 1, 16'h5678, 16'h9ABC, 16'hDEF0, 8'd2};
    vt[4] = '{"abc\n",               0, 0, 0, 16'h5678, 16'h9ABC, 16'hDEF0, 8'd2};
    vt[5] = '{"<aaaa|bbbb|cccc>\n<FFFF|0000|ffff>\n", 0, 2, 0,
              16'hFFFF, 16'h0000, 16'hFFFF, 8'd2};
    vt[6] = '{"<1111-",              0, 0, 1, 16'hFFFF, 16'h0000, 16'hFFFF, 8'd3};
    vt[7] = '{"<1111|2222|3333)",    0, 0, 1, 16'hFFFF, 16'h0000, 16'hFFFF, 8'd4};
    vt[8] = '{"<1111|2222|3333>X",   2, 0, 1, 16'hFFFF, 16'h0000, 16'hFFFF, 8'd5};

    rstn = 1'b0; i_tvalid = 1'b0; i_tdata = 8'h00;
    repeat (3) @(posedge clk); #1;
    chk("reset_tready", o_tready, 1'b0);
    chk("reset_x", data_x, 16'h0);
    chk("reset_valid", data_valid, 1'b0);
    chk("reset_error", frame_error, 1'b0);
    chk("reset_ec", error_count, 8'd0);
    rstn = 1'b1;
    #1;
    chk("tready_after_reset", o_tready, 1'b1);
    idle(2);

    for (int k = 0; k < 9; k++) begin
      v0 = nv_tot; e0 = ne_tot;
      send_str(vt[k].s, vt[k].gap);
      idle(4);
      chk($sformatf("v%0d_valid_pulses", k), nv_tot - v0, vt[k].nv);
      chk($sformatf("v%0d_error_pulses", k), ne_tot - e0, vt[k].ne);
      chk($sformatf("v%0d_x", k), data_x, vt[k].x);
      chk($sformatf("v%0d_y", k), data_y, vt[k].y);
      chk($sformatf("v%0d_z", k), data_z, vt[k].z);
      chk($sformatf("v%0d_ec", k), error_count, vt[k].ec);
    end

    // Commit latency: pulse in the cycle right after the '\n' accept edge.
    send_str("<1234|5678|9abc>", 1);
    chk("lat_before", data_valid, 1'b0);
    i_tvalid = 1'b1; i_tdata = 8'h0A;
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    chk("lat_valid_hi", data_valid, 1'b1);
    chk("lat_x", data_x, 16'h1234);
    chk("lat_z", data_z, 16'h9ABC);
    @(posedge clk); #1;
    chk("lat_valid_lo", data_valid, 1'b0);
    idle(2);

    // Error counter saturation.
    e0 = ne_tot;
    for (int k = 0; k < 260; k++) send_str("<X", 0);
    idle(3);
    chk("sat_pulses", ne_tot - e0, 260);
    chk("sat_ec", error_count, 8'hFF);
    chk("sat_hold_x", data_x, 16'h1234);

    // Asynchronous reset in the middle of a frame.
    send_str("<12", 1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_x", data_x, 16'h0);
    chk("mid_rst_y", data_y, 16'h0);
    chk("mid_rst_ec", error_count, 8'd0);
    chk("mid_rst_tready", o_tready, 1'b0);
    chk("mid_rst_err", frame_error, 1'b0);
    idle(2);
    rstn = 1'b1;
    idle(1);
    v0 = nv_tot; e0 = ne_tot;
    send_str("<0abc|1def|2345>\n", 2);
    idle(3);
    chk("post_rst_pulses", nv_tot - v0, 1);
    chk("post_rst_errs", ne_tot - e0, 0);
    chk("post_rst_x", data_x, 16'h0ABC);
    chk("post_rst_y", data_y, 16'h1DEF);
    chk("post_rst_z", data_z, 16'h2345);

`ifdef GSENSOR_FRAME_PARSER_TIMEOUT_EN
    e0 = ne_tot; v0 = nv_tot;
    send_str("<12", 0);
    idle(110);
    chk("tmo_pulse", ne_tot - e0, 1);
    chk("tmo_ec", error_count, 8'd1);
    send_str("34|1111|2222>\n", 0);
    idle(110);
    chk("tmo_no_more_err", ne_tot - e0, 1);
    chk("tmo_no_decode", nv_tot - v0, 0);
    chk("tmo_hold_x", data_x, 16'h0ABC);
`endif

    chk("valid_error_exclusive", both_tot, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
